// File: rtl/ysyx_25060173_decode_stage.sv
// Registered RV32I/RV32E decoder: one instruction + PC in, one decode bundle out.
// Latency 1 cycle (accept in N, out_valid in N+1); full throughput with out_ready high.
// Backpressure: outputs hold while stalled; SKID=1 adds a catch entry and a registered in_ready.
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_inst/in_pc from fetch;
// flush drops all buffered entries; out_valid/out_ready plus the decode bundle
// (out_pc, out_inst, out_op, out_rd/rs1/rs2, out_imm, out_rd_we, out_illegal, out_ebreak);
// dec_count counts accepted instructions.
module ysyx_25060173_decode_stage #(
    parameter int XLEN              = 32,
    parameter int RVE               = 0,
    parameter int SKID              = 1,
    parameter int HALT_ON_SELF_JUMP = 1,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [31:0]      out_inst,
    output logic [5:0]       out_op,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_rd_we,
    output logic             out_illegal,
    output logic             out_ebreak,
    output logic [CNT_W-1:0] dec_count
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [5:0]      op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic            we;
        logic            ill;
        logic            ebrk;
    } dec_t;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    // Instruction formats; FENCE carries an I-immediate but no register fields,
    // SYSTEM (ecall/ebreak) carries neither.
    localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                           FMT_U = 3'd4, FMT_J = 3'd5, FMT_F = 3'd6, FMT_N = 3'd7;

    logic [6:0]  w_opc, w_f7;
    logic [2:0]  w_f3, w_fmt;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [5:0]  w_op;
    logic [31:0] w_imm32;
    logic        w_urd, w_urs1, w_urs2, w_rve_bad, w_legal;
    dec_t        w_dec;

    assign w_opc = in_inst[6:0];
    assign w_f3  = in_inst[14:12];
    assign w_f7  = in_inst[31:25];
    assign w_rd  = in_inst[11:7];
    assign w_rs1 = in_inst[19:15];
    assign w_rs2 = in_inst[24:20];

    always_comb begin
        w_op  = 6'd0;
        w_fmt = FMT_N;
        case (w_opc)
            7'h37: begin w_op = 6'd1; w_fmt = FMT_U; end
            7'h17: begin w_op = 6'd2; w_fmt = FMT_U; end
            7'h6f: begin w_op = 6'd3; w_fmt = FMT_J; end
            7'h67: begin w_fmt = FMT_I; if (w_f3 == 3'd0) w_op = 6'd4; end
            7'h63: begin
                w_fmt = FMT_B;
                case (w_f3)
                    3'd0: w_op = 6'd5;
                    3'd1: w_op = 6'd6;
                    3'd4: w_op = 6'd7;
                    3'd5: w_op = 6'd8;
                    3'd6: w_op = 6'd9;
                    3'd7: w_op = 6'd10;
                    default: w_op = 6'd0;
                endcase
            end
            7'h03: begin
                w_fmt = FMT_I;
                case (w_f3)
                    3'd0: w_op = 6'd11;
                    3'd1: w_op = 6'd12;
                    3'd2: w_op = 6'd13;
                    3'd4: w_op = 6'd14;
                    3'd5: w_op = 6'd15;
                    default: w_op = 6'd0;
                endcase
            end
            7'h23: begin
                w_fmt = FMT_S;
                case (w_f3)
                    3'd0: w_op = 6'd16;
                    3'd1: w_op = 6'd17;
                    3'd2: w_op = 6'd18;
                    default: w_op = 6'd0;
                endcase
            end
            7'h13: begin
                w_fmt = FMT_I;
                case (w_f3)
                    3'd0: w_op = 6'd19;
                    3'd2: w_op = 6'd20;
                    3'd3: w_op = 6'd21;
                    3'd4: w_op = 6'd22;
                    3'd6: w_op = 6'd23;
                    3'd7: w_op = 6'd24;
                    3'd1: w_op = (w_f7 == 7'h00) ? 6'd25 : 6'd0;
                    default: w_op = (w_f7 == 7'h00) ? 6'd26 :
                                    (w_f7 == 7'h20) ? 6'd27 : 6'd0;
                endcase
            end
            7'h33: begin
                w_fmt = FMT_R;
                if (w_f7 == 7'h00) begin
                    case (w_f3)
                        3'd0: w_op = 6'd28;
                        3'd1: w_op = 6'd30;
                        3'd2: w_op = 6'd31;
                        3'd3: w_op = 6'd32;
                        3'd4: w_op = 6'd33;
                        3'd5: w_op = 6'd34;
                        3'd6: w_op = 6'd36;
                        default: w_op = 6'd37;
                    endcase
                end else if (w_f7 == 7'h20) begin
                    if (w_f3 == 3'd0)      w_op = 6'd29;
                    else if (w_f3 == 3'd5) w_op = 6'd35;
                end
            end
            7'h0f: begin w_fmt = FMT_F; if (w_f3 == 3'd0) w_op = 6'd38; end
            7'h73: begin
                w_fmt = FMT_N;
                if (in_inst == 32'h0000_0073)      w_op = 6'd39;
                else if (in_inst == 32'h0010_0073) w_op = 6'd40;
            end
            default: w_op = 6'd0;
        endcase

        w_urd  = (w_fmt == FMT_R) || (w_fmt == FMT_I) || (w_fmt == FMT_U) || (w_fmt == FMT_J);
        w_urs1 = (w_fmt == FMT_R) || (w_fmt == FMT_I) || (w_fmt == FMT_S) || (w_fmt == FMT_B);
        w_urs2 = (w_fmt == FMT_R) || (w_fmt == FMT_S) || (w_fmt == FMT_B);

        case (w_fmt)
            FMT_I, FMT_F: w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            FMT_S: w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            FMT_B: w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                              in_inst[30:25], in_inst[11:8], 1'b0};
            FMT_U: w_imm32 = {in_inst[31:12], 12'b0};
            FMT_J: w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                              in_inst[20], in_inst[30:21], 1'b0};
            default: w_imm32 = 32'd0;
        endcase

        // RV32E only has x0..x15; any used index with bit 4 set is out of range.
        w_rve_bad = (RVE != 0) && ((w_urd && w_rd[4]) || (w_urs1 && w_rs1[4]) ||
                                   (w_urs2 && w_rs2[4]));
        w_legal   = (w_op != 6'd0) && !w_rve_bad;

        w_dec      = '0;
        w_dec.pc   = in_pc;
        w_dec.inst = in_inst;
        if (w_legal) begin
            w_dec.op       = w_op;
            w_dec.rd       = w_urd  ? w_rd  : 5'd0;
            w_dec.rs1      = w_urs1 ? w_rs1 : 5'd0;
            w_dec.rs2      = w_urs2 ? w_rs2 : 5'd0;
            w_dec.imm      = {XLEN{w_imm32[31]}};
            w_dec.imm[31:0] = w_imm32;
            w_dec.we       = w_urd && (w_rd != 5'd0);
            w_dec.ebrk     = (w_op == 6'd40) ||
                             ((HALT_ON_SELF_JUMP != 0) && (in_inst == 32'h0000_006f));
        end else begin
            // Illegal: indices still reported raw so the trap handler can inspect them.
            w_dec.rd  = w_rd;
            w_dec.rs1 = w_rs1;
            w_dec.rs2 = w_rs2;
            w_dec.ill = 1'b1;
        end
    end

    state_t          r_state, w_next;
    dec_t            r_a, r_b;
    logic [CNT_W-1:0] r_cnt;
    logic            w_acc, w_take, w_a_load, w_a_from_b, w_b_load;

    assign out_valid = (r_state != S_EMPTY);
    assign in_ready  = (SKID != 0) ? (r_state != S_TWO) : (!out_valid || out_ready);
    assign w_acc     = in_valid && in_ready && !flush;
    assign w_take    = out_valid && out_ready;

    always_comb begin
        w_next     = r_state;
        w_a_load   = 1'b0;
        w_a_from_b = 1'b0;
        w_b_load   = 1'b0;
        if (flush) begin
            w_next = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_acc) begin w_next = S_ONE; w_a_load = 1'b1; end
                S_ONE: begin
                    if (w_take && w_acc)  w_a_load = 1'b1;
                    else if (w_take)      w_next = S_EMPTY;
                    else if (w_acc && (SKID != 0)) begin
                        w_next   = S_TWO;
                        w_b_load = 1'b1;
                    end
                end
                S_TWO: if (w_take) begin w_next = S_ONE; w_a_from_b = 1'b1; end
                default: w_next = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_a_load)        r_a <= w_dec;
            else if (w_a_from_b) r_a <= r_b;
            if (w_b_load)        r_b <= w_dec;
            if (w_acc)           r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_pc      = r_a.pc;
    assign out_inst    = r_a.inst;
    assign out_op      = r_a.op;
    assign out_rd      = r_a.rd;
    assign out_rs1     = r_a.rs1;
    assign out_rs2     = r_a.rs2;
    assign out_imm     = r_a.imm;
    assign out_rd_we   = r_a.we;
    assign out_illegal = r_a.ill;
    assign out_ebreak  = r_a.ebrk;
    assign dec_count   = r_cnt;
endmodule
